pri_req_latch: RTL
==================

PRI_REQ_LATCH -- requirements
Module: pri_req_latch

Interface
REQ-001 Parameter: PRI_HIGH, default 1, 1 = bit 7 highest priority and bit 0 lowest; 0 = bit 0 highest and bit 7 lowest.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req_in  input  8  request lines; a high bit in any cycle posts a request on that channel.
REQ-005 Port: ack  input  1  consumer accepts the offered index; meaningful only while valid=1.
REQ-006 Port: pend  output  8  registered pending-request vector.
REQ-007 Port: idx  output  3  registered index of the offered channel, binary-encoded (bit 7 -> 3'b111).
REQ-008 Port: valid  output  1  registered; high while idx holds an offered request.
REQ-009 Port: drop_cnt  output  8  registered, saturating count of requests posted on channels that are already pending.

Function
REQ-010 The block SHALL set pend[i] on the clock edge after any cycle in which req_in[i]=1; pend bits are sticky until granted.
REQ-011 The FSM SHALL have three states: IDLE (valid=0), OFFER (valid=1), CLEAR (valid=0).
REQ-012 IDLE -> OFFER when pend is nonzero; on that same edge, idx SHALL load the highest-priority set bit of pend.
REQ-013 Latency: req_in high in cycle N, pend set at edge N+1, valid=1 with idx at edge N+2, starting from IDLE with pend=0.
REQ-014 In OFFER, idx and valid SHALL be held stable until ack=1; a higher-priority request arriving in OFFER SHALL NOT change idx.
REQ-015 OFFER with ack=1 -> CLEAR on that edge: pend[idx] is cleared, valid drops to 0, drop_cnt is evaluated as usual.
REQ-016 CLEAR SHALL last exactly one cycle, then go to OFFER if pend is nonzero (re-encoding pend) or to IDLE otherwise.
REQ-017 Back-to-back grants: a consecutive valid pulse SHALL come no sooner than 2 cycles after the ack edge.
REQ-018 Simultaneous set and clear on the same bit in one cycle: the set wins, pend[i] stays 1, and drop_cnt is not incremented.
REQ-019 drop_cnt SHALL increment by the number of bits i where req_in[i]=1 and pend[i]=1 (excluding the bit being cleared that cycle); it saturates at 255 and never wraps.
REQ-020 ack in IDLE or CLEAR SHALL be ignored.

Reset
REQ-021 While rst=1, regardless of clk: pend=0, idx=0, valid=0, drop_cnt=0, state=IDLE.
REQ-022 Reset asserted mid-OFFER SHALL discard all pending requests; after release the block resumes from IDLE.
REQ-023 Requests present in the first cycle after rst deasserts SHALL be latched normally.

Configuration
REQ-024 Macro PRI_MASK_EN, when defined, SHALL add the port mask (input, 8 bits): pend bits with mask[i]=1 still latch, but are excluded from selection in IDLE and CLEAR.
REQ-025 With PRI_MASK_EN defined, an offered idx is not withdrawn if mask changes during OFFER, and a pend vector whose bits are all masked SHALL keep the FSM in IDLE.
REQ-026 Without PRI_MASK_EN, the mask port SHALL be absent and every pend bit SHALL be eligible.

Verification
REQ-027 Scenario 1: reset, then req_in=8'b10000000 for 1 cycle -> pend=8'h80 at edge+1; valid=1 and idx=3'b111 at edge+2; ack 1 cycle -> pend=0, valid=0, state IDLE.
REQ-028 Scenario 2: req_in=8'b00100100 for 1 cycle, ack each offer -> idx=5 then idx=2 (PRI_HIGH=1); with PRI_HIGH=0 -> idx=2 then idx=5; each valid pulse is separated by at least 2 cycles after its ack.
REQ-029 Scenario 3: idx=2 offered, then req_in=8'b10000000 arrives without ack -> idx stays 2; after ack, CLEAR, then idx=7.
REQ-030 Scenario 4: pend[3]=1 and req_in=8'b00001000 for 300 cycles -> drop_cnt=255 (saturated); req_in[3] coinciding with an ack on idx=3 -> pend[3] remains 1.
REQ-031 Scenario 5: assert rst during OFFER with pend=8'hFF -> pend, idx, valid and drop_cnt all read 0 immediately, before any clk edge.
REQ-032 Scenario 6 (PRI_MASK_EN): mask=8'hF0, req_in=8'h90 -> idx=4 is never offered; pend=8'h90 and valid=0; set mask=8'h00 -> idx=7 offered.

Source files
------------

// File: rtl/pri_req_latch.sv
// Sticky 8-channel request latch with a fixed-priority offer/ack handshake.
// Optional PRI_MASK_EN macro adds a mask port that hides pending bits from selection.
module pri_req_latch #(
  parameter int unsigned PRI_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       ack,
`ifdef PRI_MASK_EN
  input  logic [7:0] mask,
`endif
  output logic [7:0] pend,
  output logic [2:0] idx,
  output logic       valid,
  output logic [7:0] drop_cnt
);

  localparam int unsigned NCH = 8;
  localparam int unsigned IW  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NCH-1:0]  r_pend;
  logic [NCH-1:0]  w_pend_nxt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic [7:0]      r_drop;
  logic [7:0]      w_drop_nxt;

  logic [NCH-1:0]  w_clr;
  logic [NCH-1:0]  w_dup;
  logic [3:0]      w_dup_cnt;
  logic [8:0]      w_drop_sum;
  logic [NCH-1:0]  w_elig;
  logic [IW-1:0]   w_enc;
  logic            w_any;

  assign pend     = r_pend;
  assign idx      = r_idx;
  assign valid    = r_valid;
  assign drop_cnt = r_drop;

  // Pending vector update; a new request on the granted bit overrides its clear.
  always_comb begin
    w_clr = '0;
    if (r_state == S_OFFER && ack) begin
      w_clr[r_idx] = 1'b1;
    end
    w_pend_nxt = (r_pend & ~w_clr) | req_in;
    w_dup      = req_in & r_pend & ~w_clr;
  end

  // Saturating count of requests that landed on already-pending channels.
  always_comb begin
    w_dup_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_dup_cnt = w_dup_cnt + 4'(w_dup[i]);
    end
    w_drop_sum = {1'b0, r_drop} + 9'(w_dup_cnt);
    w_drop_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

`ifdef PRI_MASK_EN
  assign w_elig = r_pend & ~mask;
`else
  assign w_elig = r_pend;
`endif

  // Fixed-priority encoder; the last match in scan order wins.
  always_comb begin
    w_enc = '0;
    w_any = |w_elig;
    for (int i = 0; i < NCH; i++) begin
      if (PRI_HIGH != 0) begin
        if (w_elig[i]) w_enc = IW'(i);
      end else begin
        if (w_elig[NCH-1-i]) w_enc = IW'(NCH-1-i);
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE, S_CLEAR: begin
        if (w_any) begin
          w_state_nxt = S_OFFER;
          w_idx_nxt   = w_enc;
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      S_OFFER: begin
        if (ack) begin
          w_state_nxt = S_CLEAR;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

endmodule
